// File: rtl/aes_pkg.sv
// Shared AES-128 sizing, CBC controller timing constants and state encoding.
package aes_pkg;

  localparam int BLOCK_W   = 128;
  localparam int Nb        = 4;
  localparam int Nk        = 4;
  localparam int Nr        = 10;
  localparam int KEY_WAIT  = Nb * (Nr + 1) - (Nk - 1);
  localparam int CORE_LAT  = 10;
  localparam int KEY_CNT_W = 6;
  localparam int LAT_CNT_W = 4;

  typedef enum logic [1:0] {
    ST_WAIT_KEY = 2'd0,
    ST_IDLE     = 2'd1,
    ST_RUN      = 2'd2,
    ST_OUT      = 2'd3
  } cbc_state_e;

  function automatic logic [BLOCK_W-1:0] cbc_unchain(
    input logic [BLOCK_W-1:0] blk,
    input logic [BLOCK_W-1:0] chain
  );
    return blk ^ chain;
  endfunction

endpackage

// File: rtl/cbc_decrypt_ctrl.sv
// CBC decryption controller: waits for the key schedule, feeds one ciphertext
// block to the inverse cipher core and unchains its output into plaintext.
module cbc_decrypt_ctrl
  import aes_pkg::*;
(
  input  logic               clk,
  input  logic               reset,
  input  logic               iv_load,
  input  logic [BLOCK_W-1:0] iv,
  input  logic               ct_valid,
  output logic               ct_ready,
  input  logic [BLOCK_W-1:0] ct,
  output logic [BLOCK_W-1:0] core_in,
  input  logic [BLOCK_W-1:0] core_out,
  output logic               pt_valid,
  input  logic               pt_ready,
  output logic [BLOCK_W-1:0] pt,
  output logic               busy
);

  localparam logic [KEY_CNT_W-1:0] KEY_LAST = KEY_CNT_W'(KEY_WAIT - 1);
  localparam logic [LAT_CNT_W-1:0] LAT_LAST = LAT_CNT_W'(CORE_LAT - 1);

  cbc_state_e             state_r;
  logic [KEY_CNT_W-1:0]   key_cnt_r;
  logic [LAT_CNT_W-1:0]   lat_cnt_r;
  logic [BLOCK_W-1:0]     chain_r;
  logic [BLOCK_W-1:0]     ct_hold_r;

  // An IV load in IDLE takes the cycle, so intake is refused while it is high.
  assign ct_ready = (state_r == ST_IDLE) & ~iv_load;

  // Controller FSM with its counters, chaining value and registered outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r   <= ST_WAIT_KEY;
      key_cnt_r <= {KEY_CNT_W{1'b0}};
      lat_cnt_r <= {LAT_CNT_W{1'b0}};
      chain_r   <= {BLOCK_W{1'b0}};
      ct_hold_r <= {BLOCK_W{1'b0}};
      core_in   <= {BLOCK_W{1'b0}};
      pt        <= {BLOCK_W{1'b0}};
      pt_valid  <= 1'b0;
      busy      <= 1'b1;
    end else begin
      case (state_r)
        ST_WAIT_KEY: begin
          if (iv_load) begin
            chain_r <= iv;
          end
          if (key_cnt_r == KEY_LAST) begin
            key_cnt_r <= {KEY_CNT_W{1'b0}};
            state_r   <= ST_IDLE;
            busy      <= 1'b0;
          end else begin
            key_cnt_r <= key_cnt_r + {{(KEY_CNT_W-1){1'b0}}, 1'b1};
          end
        end
        ST_IDLE: begin
          if (iv_load) begin
            chain_r <= iv;
          end else if (ct_valid && ct_ready) begin
            core_in   <= ct;
            ct_hold_r <= ct;
            lat_cnt_r <= LAT_LAST;
            state_r   <= ST_RUN;
            busy      <= 1'b1;
          end
        end
        ST_RUN: begin
          // The ciphertext just consumed becomes the chaining value for the next block.
          if (lat_cnt_r == {LAT_CNT_W{1'b0}}) begin
            pt       <= cbc_unchain(core_out, chain_r);
            chain_r  <= ct_hold_r;
            pt_valid <= 1'b1;
            state_r  <= ST_OUT;
          end else begin
            lat_cnt_r <= lat_cnt_r - {{(LAT_CNT_W-1){1'b0}}, 1'b1};
          end
        end
        ST_OUT: begin
          if (pt_ready) begin
            pt_valid <= 1'b0;
            busy     <= 1'b0;
            state_r  <= ST_IDLE;
          end
        end
        default: begin
          state_r   <= ST_WAIT_KEY;
          key_cnt_r <= {KEY_CNT_W{1'b0}};
          pt_valid  <= 1'b0;
          busy      <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_cbc_decrypt_ctrl.sv
// Directed bench for cbc_decrypt_ctrl; a vector-table core model with
// CORE_LAT stability latency stands in for the AES inverse cipher.
module tb_cbc_decrypt_ctrl;
  import aes_pkg::*;

  localparam logic [127:0] KAT_CT = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] KAT_PT = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] SP_IV  = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] SP_CT1 = 128'h7649abac8119b246cee98e9b12e9197d;
  localparam logic [127:0] SP_CT2 = 128'h5086cb9b507219ee95db113a917678b2;
  localparam logic [127:0] SP_PT1 = 128'h6bc1bee22e409f96e93d7e117393172a;
  localparam logic [127:0] SP_PT2 = 128'hae2d8a571e03ac9c9eb76fac45af8e51;
  // KAT_CT decrypted under key 000102..0f, then unchained with SP_CT2.
  localparam logic [127:0] BP_PT  = 128'h5097e9a814277f991d42bb815dab964d;

  logic         clk = 1'b0;
  logic         reset;
  logic         iv_load;
  logic [127:0] iv;
  logic         ct_valid;
  logic         ct_ready;
  logic [127:0] ct;
  logic [127:0] core_in;
  logic [127:0] core_out;
  logic         pt_valid;
  logic         pt_ready;
  logic [127:0] pt;
  logic         busy;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  // Raw inverse-cipher outputs for the vectors used here (before unchaining).
  function automatic logic [127:0] inv_model(input logic [127:0] blk);
    case (blk)
      KAT_CT:  return KAT_PT;
      SP_CT1:  return 128'h6bc0bce12a459991e134741a7f9e1925;
      SP_CT2:  return 128'hd86421fb9f1a1eda505ee1375746972c;
      default: return 128'h0;
    endcase
  endfunction

  logic [127:0] seen_in = 128'h0;
  int           stable_cnt = 0;

  always @(negedge clk) begin
    if (core_in !== seen_in) stable_cnt <= 0;
    else if (stable_cnt < 1000) stable_cnt <= stable_cnt + 1;
    seen_in <= core_in;
  end

  assign core_out = (stable_cnt >= CORE_LAT - 1) ? inv_model(core_in) : ~inv_model(core_in);

  cbc_decrypt_ctrl dut (
    .clk(clk), .reset(reset), .iv_load(iv_load), .iv(iv),
    .ct_valid(ct_valid), .ct_ready(ct_ready), .ct(ct),
    .core_in(core_in), .core_out(core_out),
    .pt_valid(pt_valid), .pt_ready(pt_ready), .pt(pt), .busy(busy)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_pt(output int cyc);
    cyc = 0;
    while (!pt_valid && cyc < 64) begin
      tick();
      cyc++;
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; iv_load = 1'b0; iv = 128'h0; pt_ready = 1'b0;
    ct_valid = 1'b1; ct = KAT_CT;
    repeat (3) tick();
    checks++;
    if (ct_ready !== 1'b0 || pt_valid !== 1'b0 || busy !== 1'b1) begin
      errors++;
      $display("FAIL reset_ctrl: got rdy=%b pv=%b busy=%b want 0 0 1", ct_ready, pt_valid, busy);
    end
    checks++;
    if (pt !== 128'h0 || core_in !== 128'h0) begin
      errors++;
      $display("FAIL reset_data: got pt=%h core_in=%h want zeros", pt, core_in);
    end
  endtask

  task automatic test_key_wait(input string tag);
    logic exp_rdy;
    reset = 1'b0;
    for (int k = 1; k <= KEY_WAIT; k++) begin
      tick();
      exp_rdy = (k == KEY_WAIT);
      checks++;
      if (ct_ready !== exp_rdy || busy !== ~exp_rdy || pt_valid !== 1'b0 || core_in !== 128'h0) begin
        errors++;
        $display("FAIL key_wait_%s cycle %0d: got rdy=%b busy=%b pv=%b core_in=%h want rdy=%b",
                 tag, k, ct_ready, busy, pt_valid, core_in, exp_rdy);
      end
    end
  endtask

  task automatic test_first_block();
    int cyc;
    tick();
    checks++;
    if (core_in !== KAT_CT || busy !== 1'b1 || ct_ready !== 1'b0) begin
      errors++;
      $display("FAIL kat_accept: got core_in=%h busy=%b rdy=%b want %h 1 0", core_in, busy, ct_ready, KAT_CT);
    end
    ct_valid = 1'b0;
    wait_pt(cyc);
    checks++;
    if (cyc != CORE_LAT || pt !== KAT_PT) begin
      errors++;
      $display("FAIL kat_pt: got %0d cycles pt=%h want %0d cycles pt=%h", cyc, pt, CORE_LAT, KAT_PT);
    end
    pt_ready = 1'b1;
    tick();
    pt_ready = 1'b0;
    checks++;
    if (pt_valid !== 1'b0 || ct_ready !== 1'b1 || busy !== 1'b0) begin
      errors++;
      $display("FAIL kat_release: got pv=%b rdy=%b busy=%b want 0 1 0", pt_valid, ct_ready, busy);
    end
  endtask

  task automatic test_sp800(input string tag);
    int cyc;
    ct_valid = 1'b1; ct = SP_CT1; iv_load = 1'b1; iv = SP_IV;
    #1;
    checks++;
    if (ct_ready !== 1'b0) begin
      errors++;
      $display("FAIL iv_priority_%s: got ct_ready=%b want 0", tag, ct_ready);
    end
    tick();
    iv_load = 1'b0;
    #1;
    checks++;
    if (ct_ready !== 1'b1) begin
      errors++;
      $display("FAIL iv_done_%s: got ct_ready=%b want 1", tag, ct_ready);
    end
    tick();
    ct_valid = 1'b0;
    checks++;
    if (core_in !== SP_CT1) begin
      errors++;
      $display("FAIL sp1_accept_%s: got core_in=%h want %h", tag, core_in, SP_CT1);
    end
    wait_pt(cyc);
    checks++;
    if (cyc != CORE_LAT || pt !== SP_PT1) begin
      errors++;
      $display("FAIL sp1_pt_%s: got %0d cycles pt=%h want %0d cycles pt=%h", tag, cyc, pt, CORE_LAT, SP_PT1);
    end
    pt_ready = 1'b1;
    tick();
    pt_ready = 1'b0;
    checks++;
    if (ct_ready !== 1'b1 || pt_valid !== 1'b0) begin
      errors++;
      $display("FAIL sp1_release_%s: got rdy=%b pv=%b want 1 0", tag, ct_ready, pt_valid);
    end
    // Second block, with a stray IV load while it is in flight.
    ct_valid = 1'b1; ct = SP_CT2;
    tick();
    ct_valid = 1'b0; iv_load = 1'b1; iv = {128{1'b1}};
    tick();
    tick();
    iv_load = 1'b0;
    wait_pt(cyc);
    checks++;
    if (cyc != CORE_LAT - 2 || pt !== SP_PT2) begin
      errors++;
      $display("FAIL sp2_pt_%s: got %0d cycles pt=%h want %0d cycles pt=%h", tag, cyc, pt, CORE_LAT - 2, SP_PT2);
    end
    pt_ready = 1'b1;
    tick();
    pt_ready = 1'b0;
  endtask

  task automatic test_back_to_back();
    int           cyc;
    logic [127:0] hold_pt;
    ct_valid = 1'b1; ct = KAT_CT;
    tick();
    ct_valid = 1'b0;
    wait_pt(cyc);
    checks++;
    if (cyc != CORE_LAT || pt !== BP_PT) begin
      errors++;
      $display("FAIL bp_pt: got %0d cycles pt=%h want %0d cycles pt=%h", cyc, pt, CORE_LAT, BP_PT);
    end
    hold_pt = BP_PT;
    ct_valid = 1'b1; ct = SP_CT1;
    for (int i = 0; i < 5; i++) begin
      tick();
      checks++;
      if (pt_valid !== 1'b1 || pt !== hold_pt || ct_ready !== 1'b0 || core_in !== KAT_CT) begin
        errors++;
        $display("FAIL bp_stall %0d: got pv=%b pt=%h rdy=%b want 1 %h 0", i, pt_valid, pt, ct_ready, hold_pt);
      end
    end
    pt_ready = 1'b1;
    tick();
    pt_ready = 1'b0;
    #1;
    checks++;
    if (ct_ready !== 1'b1 || pt_valid !== 1'b0) begin
      errors++;
      $display("FAIL bp_handshake: got rdy=%b pv=%b want 1 0", ct_ready, pt_valid);
    end
    tick();
    checks++;
    if (core_in !== SP_CT1 || busy !== 1'b1) begin
      errors++;
      $display("FAIL bp_next_accept: got core_in=%h busy=%b want %h 1", core_in, busy, SP_CT1);
    end
  endtask

  task automatic test_reset_mid_run();
    ct_valid = 1'b0;
    tick();
    tick();
    #2;
    reset = 1'b1;
    #1;
    checks++;
    if (ct_ready !== 1'b0 || pt_valid !== 1'b0 || busy !== 1'b1 || pt !== 128'h0 || core_in !== 128'h0) begin
      errors++;
      $display("FAIL mid_reset: got rdy=%b pv=%b busy=%b pt=%h core_in=%h want reset values",
               ct_ready, pt_valid, busy, pt, core_in);
    end
    repeat (2) tick();
  endtask

  initial begin
    test_reset();
    test_key_wait("boot");
    test_first_block();
    test_sp800("boot");
    test_back_to_back();
    test_reset_mid_run();
    test_key_wait("rerun");
    test_sp800("rerun");
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1);
  end

endmodule
